// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: per-channel PLL lock/relock integrity checker; define PLL_LOCK_TIMEOUT_EN to add a WAIT_LOCK timeout
`timescale 1ns/1ps
module pll_lock_monitor #(
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 3,
  parameter int MAX_RELOCK   = 0,
  parameter int RELOCK_W     = 4,
  parameter int ERR_CNT_W    = 3,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic                 clk_tb,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NUM_CH-1:0]    pll_lock,
  output logic [NUM_CH-1:0]    ch_locked,
  output logic [NUM_CH-1:0]    ch_err,
  output logic                 all_locked,
  output logic                 err_chk,
  output logic [ERR_CNT_W-1:0] results_cnt
);
  typedef enum logic [1:0] {WAIT_LOCK, LOCKED, LOST, FAIL} state_t;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [RELOCK_W-1:0] relock_cnt;
    logic lk_s, tmo_hit, relock_max;
    state_t st, st_nxt;
    assign lk_s = sync[SYNC_STAGES-1];
    assign relock_max = relock_cnt == RELOCK_W'(MAX_RELOCK);
    // sync chain deliberately ignores clr so a held lock re-enters LOCKED right after clear
    always_ff @(posedge clk_tb or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], pll_lock[i]};
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = tmo_cnt == TW'(LOCK_TIMEOUT - 1);
    always_ff @(posedge clk_tb or negedge rst_n)
      if (!rst_n) tmo_cnt <= '0;
      else tmo_cnt <= (clr || st_nxt != WAIT_LOCK) ? '0 : tmo_cnt + 1'b1;
`else
    assign tmo_hit = 1'b0;
`endif
    always_comb begin
      st_nxt = clr ? WAIT_LOCK
             : st == WAIT_LOCK ? (lk_s ? LOCKED : tmo_hit ? FAIL : WAIT_LOCK)
             : st == LOCKED    ? (lk_s ? LOCKED : LOST)
             : st == LOST      ? (!lk_s ? LOST : relock_max ? FAIL : LOCKED)
             : FAIL;
    end
    always_ff @(posedge clk_tb or negedge rst_n)
      if (!rst_n) begin
        st         <= WAIT_LOCK;
        relock_cnt <= '0;
      end else begin
        st         <= st_nxt;
        relock_cnt <= clr ? '0 : (st == LOST && lk_s && !relock_max) ? relock_cnt + 1'b1 : relock_cnt;
      end
    assign ch_locked[i] = st == LOCKED;
    assign ch_err[i]    = st == LOST || st == FAIL;
  end
  assign all_locked = &ch_locked;
  always_ff @(posedge clk_tb or negedge rst_n)
    if (!rst_n) begin
      err_chk     <= 1'b0;
      results_cnt <= '0;
    end else begin
      err_chk     <= !clr && |ch_err;
      results_cnt <= clr ? '0 : (err_chk && results_cnt != '1) ? results_cnt + 1'b1 : results_cnt;
    end
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: directed table plus hand sequences for pll_lock_monitor (honours PLL_LOCK_TIMEOUT_EN)
`timescale 1ns/1ps
module tb_pll_lock_monitor;
  logic clk_tb = 1'b0, rst_n = 1'b0, clr = 1'b0, rst_n_b = 1'b0, clr_b = 1'b0;
  logic [1:0] pll_lock = 2'b00, pll_lock_b = 2'b11;
  logic [1:0] ch_locked, ch_err, ch_locked_b, ch_err_b;
  logic all_locked, err_chk, all_locked_b, err_chk_b;
  logic [2:0] results_cnt, results_cnt_b;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [1:0] pll;
    logic       clr;
    int         n;
    logic [1:0] lk;
    logic [1:0] er;
    logic       all;
    logic       ec;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[12];

  always #1 clk_tb = ~clk_tb;

  pll_lock_monitor #(.NUM_CH(2), .SYNC_STAGES(3), .MAX_RELOCK(0), .RELOCK_W(4), .ERR_CNT_W(3), .LOCK_TIMEOUT(64)) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .clr(clr), .pll_lock(pll_lock), .ch_locked(ch_locked), .ch_err(ch_err),
    .all_locked(all_locked), .err_chk(err_chk), .results_cnt(results_cnt));

  // second instance tolerates one relock
  pll_lock_monitor #(.NUM_CH(2), .SYNC_STAGES(3), .MAX_RELOCK(1), .RELOCK_W(4), .ERR_CNT_W(3), .LOCK_TIMEOUT(64)) dut_b (
    .clk_tb(clk_tb), .rst_n(rst_n_b), .clr(clr_b), .pll_lock(pll_lock_b), .ch_locked(ch_locked_b), .ch_err(ch_err_b),
    .all_locked(all_locked_b), .err_chk(err_chk_b), .results_cnt(results_cnt_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_tb);
    @(negedge clk_tb);
  endtask

  task automatic chk_main(input string tag, input logic [1:0] lk, input logic [1:0] er, input logic all,
                          input logic ec, input logic [2:0] cnt);
    chk({tag, " ch_locked"}, 32'(ch_locked), 32'(lk));
    chk({tag, " ch_err"}, 32'(ch_err), 32'(er));
    chk({tag, " all_locked"}, 32'(all_locked), 32'(all));
    chk({tag, " err_chk"}, 32'(err_chk), 32'(ec));
    chk({tag, " results_cnt"}, 32'(results_cnt), 32'(cnt));
  endtask

  task automatic b_loss(input logic fail, input string tag);
    pll_lock_b = 2'b10;
    step(3); chk({tag, " pre-loss locked"}, 32'(ch_locked_b), 32'd3);
    step(1); chk({tag, " lost err"}, 32'(ch_err_b), 32'd1);
    step(1); chk({tag, " err_chk"}, 32'(err_chk_b), 32'd1);
    pll_lock_b = 2'b11;
    step(3); chk({tag, " lost hold"}, 32'(ch_err_b), 32'd1);
    step(1);
    chk({tag, " relock err"}, 32'(ch_err_b), fail ? 32'd1 : 32'd0);
    chk({tag, " relock locked"}, 32'(ch_locked_b), fail ? 32'd2 : 32'd3);
  endtask

  initial begin
    tbl = '{
      '{2'b00, 1'b0, 10, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0},
      '{2'b11, 1'b0,  3, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0},
      '{2'b11, 1'b0,  1, 2'b11, 2'b00, 1'b1, 1'b0, 3'd0},
      '{2'b10, 1'b0,  3, 2'b11, 2'b00, 1'b1, 1'b0, 3'd0},
      '{2'b10, 1'b0,  1, 2'b10, 2'b01, 1'b0, 1'b0, 3'd0},
      '{2'b10, 1'b0,  1, 2'b10, 2'b01, 1'b0, 1'b1, 3'd0},
      '{2'b11, 1'b0,  1, 2'b10, 2'b01, 1'b0, 1'b1, 3'd1},
      '{2'b11, 1'b0,  3, 2'b10, 2'b01, 1'b0, 1'b1, 3'd4},
      '{2'b11, 1'b0,  3, 2'b10, 2'b01, 1'b0, 1'b1, 3'd7},
      '{2'b11, 1'b0,  5, 2'b10, 2'b01, 1'b0, 1'b1, 3'd7},
      '{2'b11, 1'b1,  1, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0},
      '{2'b11, 1'b0,  1, 2'b11, 2'b00, 1'b1, 1'b0, 3'd0}
    };
    pll_lock = 2'b11;
    @(negedge clk_tb);
    step(3);
    chk_main("reset", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0);
    pll_lock = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pll_lock = tbl[k].pll;
      clr = tbl[k].clr;
      step(tbl[k].n);
      chk_main($sformatf("row%0d", k), tbl[k].lk, tbl[k].er, tbl[k].all, tbl[k].ec, tbl[k].cnt);
    end
    // ch1 never locks: timeout behaviour depends on build
    rst_n = 1'b0;
    pll_lock = 2'b01;
    step(2);
    rst_n = 1'b1;
    step(63);
    chk("tmo edge63 ch_err", 32'(ch_err), 32'd0);
    chk("tmo edge63 ch_locked", 32'(ch_locked), 32'd1);
    step(1);
`ifdef PLL_LOCK_TIMEOUT_EN
    chk("tmo edge64 ch_err", 32'(ch_err), 32'd2);
    step(936);
    chk("tmo edge1000 ch_err", 32'(ch_err), 32'd2);
`else
    chk("tmo edge64 ch_err", 32'(ch_err), 32'd0);
    step(936);
    chk("tmo edge1000 ch_err", 32'(ch_err), 32'd0);
`endif
    rst_n_b = 1'b1;
    step(3);
    chk("b pre-lock all_locked", 32'(all_locked_b), 32'd0);
    step(1);
    chk("b lock all_locked", 32'(all_locked_b), 32'd1);
    b_loss(1'b0, "b relock1");
    chk("b relock1 cnt", 32'(results_cnt_b), 32'd4);
    chk("b relock1 all_locked", 32'(all_locked_b), 32'd1);
    step(1);
    chk("b relock1 cnt+1", 32'(results_cnt_b), 32'd5);
    chk("b relock1 err_chk clear", 32'(err_chk_b), 32'd0);
    step(2);
    chk("b hold cnt", 32'(results_cnt_b), 32'd5);
    rst_n_b = 1'b0;
    #0.3;
    chk("b async rst ch_locked", 32'(ch_locked_b), 32'd0);
    chk("b async rst ch_err", 32'(ch_err_b), 32'd0);
    chk("b async rst all_locked", 32'(all_locked_b), 32'd0);
    chk("b async rst err_chk", 32'(err_chk_b), 32'd0);
    chk("b async rst cnt", 32'(results_cnt_b), 32'd0);
    @(negedge clk_tb);
    rst_n_b = 1'b1;
    step(3);
    chk("b post-rst pre-lock", 32'(all_locked_b), 32'd0);
    step(1);
    chk("b post-rst lock", 32'(all_locked_b), 32'd1);
    b_loss(1'b0, "b2 relock1");
    step(1);
    chk("b2 relock1 cnt", 32'(results_cnt_b), 32'd5);
    b_loss(1'b1, "b2 relock2");
    chk("b2 relock2 cnt sat", 32'(results_cnt_b), 32'd7);
    chk("b2 relock2 all_locked", 32'(all_locked_b), 32'd0);
    step(3);
    chk("b2 fail sticky err", 32'(ch_err_b), 32'd1);
    chk("b2 fail sticky locked", 32'(ch_locked_b), 32'd2);
    chk("b2 fail cnt", 32'(results_cnt_b), 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
